// File: rtl/ps2_key_fifo_rx_pkg.sv
// Shared PS/2 receiver types and constants: scan-code prefixes, FSM state
// encodings, queued key-event layout and the frame parity check.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam int         EVT_W     = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  typedef enum logic {
    D_IDLE   = 1'b0,
    D_PREFIX = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ((^{data, par}) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_key_fifo_rx_if.sv
// Pico-side port bundle of the PS/2 key event queue.
// The receiver is the slave; the PicoBlaze input mux is the master.
interface ps2_key_fifo_rx_if #(
  parameter int CNT_W = 4
);
  logic             new_data_pico;
  logic             new_data;
  logic [7:0]       letra;
  logic             extended;
  logic             is_break;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             frame_err;

  modport master (
    output new_data_pico,
    input  new_data, letra, extended, is_break, count, overflow, frame_err
  );

  modport slave (
    input  new_data_pico,
    output new_data, letra, extended, is_break, count, overflow, frame_err
  );
endinterface

// File: rtl/ps2_key_fifo_rx_frame_rx.sv
// PS/2 line front end: synchronise and deglitch ps2c/ps2d, deframe 11-bit
// frames, check parity/stop bit and abort frames that stall.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FLT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       c_sync_r;
  logic [1:0]       d_sync_r;
  logic             filt_r;
  logic [FLT_W-1:0] filt_cnt_r;
  logic             edge_s;
  logic             strobe_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             tmo_s;
  frame_state_t     state_r;
  frame_state_t     state_nx_s;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             par_r;
  logic             shift_en_s;
  logic             par_en_s;
  logic             accept_s;
  logic             err_s;

  // Two-flop synchronisers; idle-high so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_r <= 2'b11;
      d_sync_r <= 2'b11;
    end else begin
      c_sync_r <= {c_sync_r[0], ps2c};
      d_sync_r <= {d_sync_r[0], ps2d};
    end
  end

  // A level change is accepted on the FILTER_LEN-th consecutive differing sample
  assign edge_s   = (c_sync_r[1] != filt_r) && (filt_cnt_r == FLT_W'(FILTER_LEN - 1));
  assign strobe_s = edge_s && filt_r;
  assign tmo_s    = (state_r != IDLE) && !edge_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

  // Glitch filter on the synchronised clock line
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_r     <= 1'b1;
      filt_cnt_r <= FLT_W'(0);
    end else if (c_sync_r[1] == filt_r) begin
      filt_cnt_r <= FLT_W'(0);
    end else if (edge_s) begin
      filt_r     <= c_sync_r[1];
      filt_cnt_r <= FLT_W'(0);
    end else begin
      filt_cnt_r <= filt_cnt_r + FLT_W'(1);
    end
  end

  // Stall timer: restarts on every filtered edge, idle while no frame is open
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= TMO_W'(0);
    end else if (edge_s || tmo_s || (state_r == IDLE)) begin
      tmo_cnt_r <= TMO_W'(0);
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame next-state logic
  always_comb begin
    state_nx_s = state_r;
    if (tmo_s) begin
      state_nx_s = IDLE;
    end else if (strobe_s) begin
      case (state_r)
        IDLE:    state_nx_s = (!d_sync_r[1] && rx_en) ? DATA : IDLE;
        DATA:    state_nx_s = (bit_cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  state_nx_s = STOP;
        STOP:    state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Frame output decode: shift/parity enables and stop-bit verdict
  always_comb begin
    shift_en_s = 1'b0;
    par_en_s   = 1'b0;
    accept_s   = 1'b0;
    err_s      = tmo_s;
    if (strobe_s) begin
      case (state_r)
        DATA:    shift_en_s = 1'b1;
        PARITY:  par_en_s   = 1'b1;
        STOP: begin
          accept_s = odd_parity_ok(shift_r, par_r) && d_sync_r[1];
          err_s    = !(odd_parity_ok(shift_r, par_r) && d_sync_r[1]);
        end
        default: shift_en_s = 1'b0;
      endcase
    end else begin
      shift_en_s = 1'b0;
    end
  end

  // Deframing datapath and registered result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      par_r      <= 1'b0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= accept_s;
      frame_err  <= err_s;
      if (accept_s) rx_byte <= shift_r;
      if (state_r == IDLE) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (shift_en_s) shift_r <= {d_sync_r[1], shift_r[7:1]};
      if (par_en_s) par_r <= d_sync_r[1];
    end
  end

endmodule

// File: rtl/ps2_key_fifo_rx.sv
// PS/2 keyboard receiver for the PicoBlaze: decodes E0/F0 prefixes into key
// events and buffers them in a small FIFO popped by the Pico acknowledge.
module ps2_key_fifo_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 20000,
  parameter int REPORT_MAKE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2d,
  input  logic              ps2c,
  input  logic              rx_en,
  ps2_key_fifo_rx_if.slave  pico
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic             byte_valid_s;
  logic [7:0]       rx_byte_s;
  logic             frame_err_s;
  dec_state_t       dec_r;
  dec_state_t       dec_nx_s;
  logic             ext_r;
  logic             brk_r;
  logic             ext_nx_s;
  logic             brk_nx_s;
  logic             emit_s;
  logic             wr_r;
  key_evt_t         wr_data_r;
  key_evt_t         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  key_evt_t         head_nx_s;
  logic             ack_r;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             new_data_r;
  logic [7:0]       letra_r;
  logic             extended_r;
  logic             is_break_r;
  logic             overflow_r;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .clk        (clk),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .rx_en      (rx_en),
    .byte_valid (byte_valid_s),
    .rx_byte    (rx_byte_s),
    .frame_err  (frame_err_s)
  );

  // Decoder state register with prefix flags
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_r <= D_IDLE;
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else begin
      dec_r <= dec_nx_s;
      ext_r <= ext_nx_s;
      brk_r <= brk_nx_s;
    end
  end

  // Decoder next-state logic
  always_comb begin
    dec_nx_s = dec_r;
    if (frame_err_s) begin
      dec_nx_s = D_IDLE;
    end else if (byte_valid_s) begin
      case (rx_byte_s)
        PS2_EXT, PS2_BREAK: dec_nx_s = D_PREFIX;
        default:            dec_nx_s = D_IDLE;
      endcase
    end else begin
      dec_nx_s = dec_r;
    end
  end

  // Decoder outputs: flag updates and event emission
  always_comb begin
    ext_nx_s = ext_r;
    brk_nx_s = brk_r;
    emit_s   = 1'b0;
    if (frame_err_s) begin
      ext_nx_s = 1'b0;
      brk_nx_s = 1'b0;
    end else if (byte_valid_s) begin
      case (rx_byte_s)
        PS2_EXT:   ext_nx_s = 1'b1;
        PS2_BREAK: brk_nx_s = 1'b1;
        PS2_PAUSE: begin
          ext_nx_s = 1'b0;
          brk_nx_s = 1'b0;
        end
        default: begin
          emit_s   = brk_r || (REPORT_MAKE != 0);
          ext_nx_s = 1'b0;
          brk_nx_s = 1'b0;
        end
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  // Event write stage, one cycle behind the decoded byte
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_r      <= 1'b0;
      wr_data_r <= '0;
    end else begin
      wr_r      <= emit_s;
      wr_data_r <= '{ext: ext_r, brk: brk_r, code: rx_byte_s};
    end
  end

  assign empty_s = (cnt_r == CNT_W'(0));
  assign full_s  = (cnt_r == CNT_W'(FIFO_DEPTH));
  assign pop_s   = pico.new_data_pico && !ack_r && !empty_s;
  assign push_s  = wr_r && (!full_s || pop_s);
  assign drop_s  = wr_r && full_s && !pop_s;

  // Next occupancy, read pointer and head entry as seen after this cycle
  always_comb begin
    cnt_nx_s    = cnt_r;
    rd_ptr_nx_s = rd_ptr_r;
    head_nx_s   = '0;
    if (pop_s) begin
      rd_ptr_nx_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nx_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_nx_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_nx_s = cnt_r - CNT_W'(1);
      default: cnt_nx_s = cnt_r;
    endcase
    // If nothing older survives the pop, the entry being written is the new head
    if (cnt_nx_s == CNT_W'(0)) begin
      head_nx_s = '0;
    end else if ((cnt_r - CNT_W'(pop_s)) == CNT_W'(0)) begin
      head_nx_s = wr_data_r;
    end else begin
      head_nx_s = mem_r[rd_ptr_nx_s];
    end
  end

  // Event storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data_r;
  end

  // FIFO control, ack edge detector and registered Pico-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r      <= 1'b0;
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      cnt_r      <= CNT_W'(0);
      new_data_r <= 1'b0;
      letra_r    <= 8'd0;
      extended_r <= 1'b0;
      is_break_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      ack_r      <= pico.new_data_pico;
      rd_ptr_r   <= rd_ptr_nx_s;
      cnt_r      <= cnt_nx_s;
      new_data_r <= (cnt_nx_s != CNT_W'(0));
      letra_r    <= head_nx_s.code;
      extended_r <= head_nx_s.ext;
      is_break_r <= head_nx_s.brk;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  assign pico.new_data  = new_data_r;
  assign pico.letra     = letra_r;
  assign pico.extended  = extended_r;
  assign pico.is_break  = is_break_r;
  assign pico.count     = cnt_r;
  assign pico.overflow  = overflow_r;
  assign pico.frame_err = frame_err_s;

endmodule

// File: tb/tb_ps2_key_fifo_rx.sv
// Directed scoreboard bench: two receivers share the PS/2 lines, one queuing
// break events only and one also queuing make events; rx_en selects the listener.
module tb_ps2_key_fifo_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  logic rx_en_a = 1'b0;
  logic rx_en_b = 1'b0;

  int checks = 0;
  int failures = 0;
  int err_a = 0;
  logic [9:0] qa [$];
  logic [9:0] qb [$];

  ps2_key_fifo_rx_if #(.CNT_W(4)) if_a ();
  ps2_key_fifo_rx_if #(.CNT_W(4)) if_b ();

  ps2_key_fifo_rx #(
    .FILTER_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_CYC(200), .REPORT_MAKE(0)
  ) dut_a (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en_a), .pico(if_a.slave)
  );

  ps2_key_fifo_rx #(
    .FILTER_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_CYC(200), .REPORT_MAKE(1)
  ) dut_b (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en_b), .pico(if_b.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if_a.frame_err === 1'b1) err_a++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the first nbits of a frame: start, 8 data LSB first, odd parity, stop
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      tick(25);
      ps2c = 1'b0;
      tick(50);
      ps2c = 1'b1;
      tick(25);
    end
    ps2d = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 11, 1'b0);
  endtask

  // Send a key sequence and record the event the selected receiver should queue
  task automatic key(input int sel, input bit ext, input bit brk, input logic [7:0] code,
                     input bit queued);
    if (ext) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(code);
    if (queued) begin
      if (sel == 0) qa.push_back({ext, brk, code});
      else qb.push_back({ext, brk, code});
    end
  endtask

  // Wait for a queued event, compare head with the scoreboard, then acknowledge
  task automatic pop_check(input int sel, input string tag, input bit do_ack);
    logic [9:0] exp;
    logic [9:0] got;
    logic       nd;
    int         n;
    n = 0;
    nd = (sel == 0) ? if_a.new_data : if_b.new_data;
    while (nd !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
      nd = (sel == 0) ? if_a.new_data : if_b.new_data;
    end
    check({tag, "_nd"}, {31'd0, nd}, 32'd1);
    exp = 10'h3FF;
    if (sel == 0 && qa.size() != 0) exp = qa.pop_front();
    if (sel != 0 && qb.size() != 0) exp = qb.pop_front();
    if (sel == 0) got = {if_a.extended, if_a.is_break, if_a.letra};
    else got = {if_b.extended, if_b.is_break, if_b.letra};
    check(tag, {22'd0, got}, {22'd0, exp});
    if (do_ack) begin
      if (sel == 0) if_a.new_data_pico = 1'b1;
      else if_b.new_data_pico = 1'b1;
      tick(2);
      if (sel == 0) if_a.new_data_pico = 1'b0;
      else if_b.new_data_pico = 1'b0;
      tick(2);
    end
  endtask

  initial begin
    int e0;
    if_a.new_data_pico = 1'b0;
    if_b.new_data_pico = 1'b0;
    tick(3);
    check("rst_new_data", {31'd0, if_a.new_data}, 32'd0);
    check("rst_letra", {24'd0, if_a.letra}, 32'd0);
    check("rst_count", {28'd0, if_a.count}, 32'd0);
    check("rst_ovf", {31'd0, if_a.overflow}, 32'd0);
    check("rst_ferr", {31'd0, if_a.frame_err}, 32'd0);
    reset = 1'b0;
    rx_en_a = 1'b1;
    tick(20);

    // Basic break event and pop back to empty
    key(0, 1'b0, 1'b1, 8'h2B, 1'b1);
    tick(20);
    check("brk_count1", {28'd0, if_a.count}, 32'd1);
    pop_check(0, "brk_2B", 1'b1);
    check("pop_new_data", {31'd0, if_a.new_data}, 32'd0);
    check("pop_letra", {24'd0, if_a.letra}, 32'd0);
    check("pop_count", {28'd0, if_a.count}, 32'd0);

    // Extended break, then a make code that must not be queued
    key(0, 1'b1, 1'b1, 8'h75, 1'b1);
    pop_check(0, "ext_brk_75", 1'b1);
    key(0, 1'b0, 1'b0, 8'h1C, 1'b0);
    tick(20);
    check("make_dropped", {28'd0, if_a.count}, 32'd0);

    // Make reporting receiver; receiver A is disabled and must ignore it
    rx_en_a = 1'b0;
    rx_en_b = 1'b1;
    key(1, 1'b0, 1'b0, 8'h1C, 1'b1);
    key(1, 1'b0, 1'b1, 8'h1C, 1'b1);
    tick(20);
    check("b_count2", {28'd0, if_b.count}, 32'd2);
    check("a_rx_en_off", {28'd0, if_a.count}, 32'd0);
    pop_check(1, "b_make_1C", 1'b1);
    pop_check(1, "b_brk_1C", 1'b1);
    rx_en_b = 1'b0;
    rx_en_a = 1'b1;

    // Parity error, then decoder recovery
    e0 = err_a;
    send_bits(8'h2B, 11, 1'b1);
    tick(20);
    check("par_err_pulse", err_a - e0, 32'd1);
    check("par_err_count", {28'd0, if_a.count}, 32'd0);
    key(0, 1'b0, 1'b1, 8'h33, 1'b1);
    pop_check(0, "recover_33", 1'b1);

    // Nine events into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) key(0, 1'b0, 1'b1, 8'(i), (i <= 8));
    tick(20);
    check("full_count", {28'd0, if_a.count}, 32'd8);
    check("full_ovf", {31'd0, if_a.overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) pop_check(0, "fifo_order", 1'b1);
    check("drained", {31'd0, if_a.new_data}, 32'd0);

    // Held acknowledge pops exactly once
    key(0, 1'b0, 1'b1, 8'h0A, 1'b1);
    key(0, 1'b0, 1'b1, 8'h0B, 1'b1);
    tick(20);
    check("hold_count2", {28'd0, if_a.count}, 32'd2);
    pop_check(0, "hold_head_0A", 1'b0);
    if_a.new_data_pico = 1'b1;
    tick(100);
    check("hold_count1", {28'd0, if_a.count}, 32'd1);
    if_a.new_data_pico = 1'b0;
    tick(2);
    pop_check(0, "hold_next_0B", 1'b1);

    // Stalled frame after four bits times out
    e0 = err_a;
    send_bits(8'hF0, 4, 1'b0);
    tick(400);
    check("timeout_pulse", err_a - e0, 32'd1);
    key(0, 1'b0, 1'b1, 8'h76, 1'b1);
    pop_check(0, "after_tmo_76", 1'b1);

    // Short low glitch with data low must not open a frame
    e0 = err_a;
    ps2d = 1'b0;
    tick(5);
    ps2c = 1'b0;
    tick(3);
    ps2c = 1'b1;
    tick(5);
    ps2d = 1'b1;
    tick(20);
    key(0, 1'b0, 1'b1, 8'h34, 1'b1);
    pop_check(0, "glitch_34", 1'b1);
    check("glitch_no_err", err_a - e0, 32'd0);

    // Reset in the middle of a frame
    send_bits(8'hF0, 5, 1'b0);
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2);
    check("mid_rst_nd", {31'd0, if_a.new_data}, 32'd0);
    check("mid_rst_ovf", {31'd0, if_a.overflow}, 32'd0);
    check("mid_rst_count", {28'd0, if_a.count}, 32'd0);
    key(0, 1'b0, 1'b1, 8'h35, 1'b1);
    pop_check(0, "after_rst_35", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
